// File: rtl/simple_adder.sv
// -----------------------------------------------------------------------------
// simple_adder
//
// Registered unsigned adder. Every rising edge of clk_i samples the two
// operands and registers their sum. The sum wraps modulo 2^DataWidth, or clamps
// to the all-ones value on overflow when Saturate is set. There is no
// handshake: a new result is produced every cycle with exactly one cycle of
// latency.
//
// Parameters:
//   DataWidth  operand/result width in bits (1..64)
//   Saturate   0 = wrap on overflow, 1 = clamp to 2^DataWidth-1
//
// Ports:
//   clk_i     in   1          clock, rising-edge active
//   rst_ni    in   1          asynchronous active-low reset, clears c_data_o
//   a_data_i  in   DataWidth  operand A, unsigned
//   b_data_i  in   DataWidth  operand B, unsigned
//   c_data_o  out  DataWidth  registered sum of A and B (straight from a flop)
// -----------------------------------------------------------------------------
module simple_adder #(
  parameter int unsigned DataWidth = 8,
  parameter bit          Saturate  = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] a_data_i,
  input  logic [DataWidth-1:0] b_data_i,
  output logic [DataWidth-1:0] c_data_o
);

  // Reject unsupported widths at elaboration rather than producing odd logic.
  if (DataWidth < 1 || DataWidth > 64) begin : gen_bad_width
    $error("simple_adder: DataWidth must be in 1..64");
  end

  // One extra bit keeps the carry-out visible for the saturation decision.
  logic [DataWidth:0]   sum;
  logic [DataWidth-1:0] result;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the block leaves it unassigned; that is what keeps a latch from appearing.
    sum    = {1'b0, a_data_i} + {1'b0, b_data_i};
    result = sum[DataWidth-1:0];
    if (Saturate && sum[DataWidth]) begin
      result = '1;
    end
  end

  // The output register is the only state. Reset is asynchronous on assertion;
  // release is naturally synchronous because the next capture happens on the
  // first rising edge that sees rst_ni high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    if (!rst_ni) begin
      c_data_o <= '0;
    end else begin
      c_data_o <= result;
    end
  end

endmodule

// File: tb/tb_simple_adder.sv
// -----------------------------------------------------------------------------
// tb_simple_adder
//
// Drives one wrap-mode and one saturate-mode instance of simple_adder (both
// DataWidth=8) from the same operands. Directed cases carry their expected
// results as constants; random cases are predicted by a plain-arithmetic model
// and queued as a scoreboard for the cycle after the operands are sampled.
// -----------------------------------------------------------------------------
module tb_simple_adder;

  logic       clk_i;
  logic       rst_ni;
  logic [7:0] a_data;
  logic [7:0] b_data;
  logic [7:0] c_wrap;
  logic [7:0] c_sat;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Expected output for the result currently on the output register.
  logic [7:0] last_wrap;
  logic [7:0] last_sat;

  // Scoreboard: expected results for the operands sampled at the next edge.
  logic [7:0] exp_wrap_q[$];
  logic [7:0] exp_sat_q[$];

  simple_adder #(.DataWidth(8), .Saturate(1'b0)) u_wrap (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .a_data_i(a_data),
    .b_data_i(b_data),
    .c_data_o(c_wrap)
  );

  simple_adder #(.DataWidth(8), .Saturate(1'b1)) u_sat (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .a_data_i(a_data),
    .b_data_i(b_data),
    .c_data_o(c_sat)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: the mathematical sum, reduced by the mode's rule.
  function automatic logic [7:0] ref_wrap(input int unsigned a, input int unsigned b);
    return 8'((a + b) % 256);
  endfunction

  function automatic logic [7:0] ref_sat(input int unsigned a, input int unsigned b);
    return (a + b > 255) ? 8'd255 : 8'(a + b);
  endfunction

  // Present operands at a falling edge, confirm the output does not react to
  // the input change, then check the registered result just after the rising
  // edge against the scoreboard.
  task automatic apply(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ew, input logic [7:0] es);
    @(negedge clk_i);
    a_data = a;
    b_data = b;
    exp_wrap_q.push_back(ew);
    exp_sat_q.push_back(es);
    #1;
    check({tag, "_hold_wrap"}, c_wrap, last_wrap);
    check({tag, "_hold_sat"}, c_sat, last_sat);
    @(posedge clk_i);
    #1;
    last_wrap = exp_wrap_q.pop_front();
    last_sat  = exp_sat_q.pop_front();
    check({tag, "_wrap"}, c_wrap, last_wrap);
    check({tag, "_sat"}, c_sat, last_sat);
  endtask

  typedef struct {
    string      tag;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ew;
    logic [7:0] es;
  } vec_t;

  vec_t directed[$];

  initial begin
    // Create a real falling edge on rst_ni so the async reset fires.
    rst_ni = 1'b1;
    a_data = 8'h55;
    b_data = 8'h22;
    #1 rst_ni = 1'b0;
    #1;
    check("reset_async_wrap", c_wrap, 8'd0);
    check("reset_async_sat", c_sat, 8'd0);

    // Reset held across several edges with nonzero operands.
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_held_wrap", c_wrap, 8'd0);
    check("reset_held_sat", c_sat, 8'd0);

    // Release between edges with 3+4: nothing before the edge, 7 after it.
    @(negedge clk_i);
    rst_ni = 1'b1;
    a_data = 8'd3;
    b_data = 8'd4;
    #1;
    check("pre_edge_wrap", c_wrap, 8'd0);
    check("pre_edge_sat", c_sat, 8'd0);
    @(posedge clk_i);
    #1;
    check("first_edge_wrap", c_wrap, 8'd7);
    check("first_edge_sat", c_sat, 8'd7);
    last_wrap = 8'd7;
    last_sat  = 8'd7;

    // Back-to-back and boundary cases, expected values written out by hand.
    directed.push_back('{"b2b_0", 8'd10,  8'd20,  8'd30,  8'd30});
    directed.push_back('{"b2b_1", 8'd100, 8'd27,  8'd127, 8'd127});
    directed.push_back('{"b2b_2", 8'd1,   8'd254, 8'd255, 8'd255});
    directed.push_back('{"ovf",   8'd200, 8'd100, 8'd44,  8'd255});
    directed.push_back('{"exact", 8'd255, 8'd1,   8'd0,   8'd255});
    directed.push_back('{"max",   8'd255, 8'd255, 8'd254, 8'd255});
    directed.push_back('{"zero",  8'd0,   8'd0,   8'd0,   8'd0});
    directed.push_back('{"nof",   8'd127, 8'd128, 8'd255, 8'd255});
    directed.push_back('{"mid",   8'd100, 8'd27,  8'd127, 8'd127});
    foreach (directed[i]) begin
      apply(directed[i].tag, directed[i].a, directed[i].b, directed[i].ew, directed[i].es);
    end

    // Reset asserted between edges after a nonzero result.
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_reset_wrap", c_wrap, 8'd0);
    check("mid_reset_sat", c_sat, 8'd0);
    @(posedge clk_i);
    #1;
    check("mid_reset_held_wrap", c_wrap, 8'd0);
    check("mid_reset_held_sat", c_sat, 8'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    a_data = 8'd0;
    b_data = 8'd0;
    last_wrap = 8'd0;
    last_sat  = 8'd0;

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      int unsigned ra;
      int unsigned rb;
      ra = $urandom_range(255);
      rb = $urandom_range(255);
      apply($sformatf("rand%0d", i), 8'(ra), 8'(rb), ref_wrap(ra, rb), ref_sat(ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
